// File: rtl/goertzel_acq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : goertzel_acq_sequencer
// Brief   : Frame sequencer that clears the Goertzel core, streams N decimated
//           ADC samples into it, waits for the result and flags done/timeout.
// Revision: 1.0 - initial release
// ============================================================================
module goertzel_acq_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int DEC_WIDTH  = 8,
    parameter int RES_WIDTH  = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic                  cfg_continuous,
    input  logic [CNT_WIDTH-1:0]  cfg_num_samples,
    input  logic [DEC_WIDTH-1:0]  cfg_decimation,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  gz_clear,
    output logic                  gz_valid,
    output logic [DATA_WIDTH-1:0] gz_data,
    output logic                  gz_last,
    input  logic                  gz_result_valid,
    input  logic [RES_WIDTH-1:0]  gz_result,
    output logic [RES_WIDTH-1:0]  result,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [15:0]           frame_cnt,
    output logic                  irq
);

    localparam int c_WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_ACQUIRE = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [DEC_WIDTH-1:0]  r_dec;
    logic [CNT_WIDTH-1:0]  r_samp_cnt;
    logic [DEC_WIDTH-1:0]  r_dec_cnt;
    logic [c_WD_WIDTH-1:0] r_wd_cnt;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_dec       <= '0;
            r_samp_cnt  <= '0;
            r_dec_cnt   <= '0;
            r_wd_cnt    <= '0;
            gz_clear    <= 1'b0;
            gz_valid    <= 1'b0;
            gz_data     <= '0;
            gz_last     <= 1'b0;
            result      <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            irq         <= 1'b0;
        end else begin
            gz_clear <= 1'b0;
            gz_valid <= 1'b0;
            gz_last  <= 1'b0;
            irq      <= 1'b0;
            // Abort outranks every other event, including a same-cycle result.
            if (cfg_abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_start && !cfg_abort && cfg_num_samples != '0) begin
                            r_num       <= cfg_num_samples;
                            r_dec       <= cfg_decimation;
                            done        <= 1'b0;
                            timeout_err <= 1'b0;
                            gz_clear    <= 1'b1;
                            r_state     <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        r_samp_cnt <= '0;
                        r_dec_cnt  <= '0;
                        r_state    <= S_ACQUIRE;
                    end
                    S_ACQUIRE: begin
                        if (adc_valid) begin
                            r_dec_cnt <= (r_dec_cnt == r_dec) ? '0 : r_dec_cnt + DEC_WIDTH'(1);
                            if (r_dec_cnt == '0) begin
                                gz_valid   <= 1'b1;
                                gz_data    <= adc_data;
                                r_samp_cnt <= r_samp_cnt + CNT_WIDTH'(1);
                                if (r_samp_cnt == r_num - CNT_WIDTH'(1)) begin
                                    gz_last  <= 1'b1;
                                    r_wd_cnt <= '0;
                                    r_state  <= S_WAIT;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (gz_result_valid) begin
                            result    <= gz_result;
                            done      <= 1'b1;
                            irq       <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            // Continuous mode is sampled live at the frame boundary so
                            // clearing it lets the frame in flight finish cleanly.
                            if (cfg_continuous) begin
                                gz_clear <= 1'b1;
                                r_state  <= S_CLEAR;
                            end else begin
                                r_state  <= S_IDLE;
                            end
                        end else if (r_wd_cnt == c_WD_WIDTH'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            irq         <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + c_WD_WIDTH'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_goertzel_acq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_goertzel_acq_sequencer
// Brief   : Scenario bench; forwarded samples are scoreboarded via a queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_goertzel_acq_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_continuous = 1'b0;
    logic [15:0] cfg_num_samples = '0;
    logic [7:0]  cfg_decimation = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        gz_clear, gz_valid, gz_last;
    logic [15:0] gz_data;
    logic        gz_result_valid = 1'b0;
    logic [31:0] gz_result = '0;
    logic [31:0] result;
    logic        busy, done, timeout_err, irq;
    logic [15:0] frame_cnt;

    goertzel_acq_sequencer #(
        .DATA_WIDTH(16), .CNT_WIDTH(16), .DEC_WIDTH(8), .RES_WIDTH(32), .TIMEOUT(256)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_continuous(cfg_continuous),
        .cfg_num_samples(cfg_num_samples), .cfg_decimation(cfg_decimation),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .gz_clear(gz_clear), .gz_valid(gz_valid), .gz_data(gz_data), .gz_last(gz_last),
        .gz_result_valid(gz_result_valid), .gz_result(gz_result),
        .result(result), .busy(busy), .done(done), .timeout_err(timeout_err),
        .frame_cnt(frame_cnt), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_clear = 0;
    int          n_irq   = 0;
    logic [31:0] exp_result = '0;
    logic [15:0] exp_frames = '0;

    // Scoreboard monitor: every core strobe must match the next expected sample.
    always @(negedge ACLK) begin
        if (gz_clear) n_clear++;
        if (irq) n_irq++;
        if (gz_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL gz_valid_unexpected: got data=%h last=%b, required no strobe", gz_data, gz_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({gz_data, gz_last} !== {mon_e.data, mon_e.last}) begin
                    n_fail++;
                    $display("FAIL gz_sample: got data=%h last=%b, required data=%h last=%b",
                             gz_data, gz_last, mon_e.data, mon_e.last);
                end
            end
        end else if (gz_last) begin
            n_tests++;
            n_fail++;
            $display("FAIL gz_last_alone: got gz_last=1 without gz_valid, required 0");
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_frame(input int n, input int d, input bit cont);
        cfg_num_samples = 16'(n);
        cfg_decimation  = 8'(d);
        cfg_continuous  = cont;
        cfg_start       = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
    endtask

    // Drives consecutive samples and pushes the ones the sequencer should forward.
    task automatic send(input int count, input int base, input int n, input int d);
        int   fwd;
        exp_t e;
        fwd = 0;
        for (int i = 0; i < count; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(base + i);
            if ((i % (d + 1)) == 0 && fwd < n) begin
                e.data = 16'(base + i);
                e.last = (fwd == n - 1);
                exp_q.push_back(e);
                fwd++;
            end
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic result_pulse(input logic [31:0] v);
        gz_result       = v;
        gz_result_valid = 1'b1;
        tick();
        gz_result_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({gz_clear, gz_valid, gz_data, gz_last, result, busy, done, timeout_err, frame_cnt, irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clr=%b v=%b d=%h l=%b res=%h busy=%b done=%b to=%b fc=%0d irq=%b, required all 0",
                     gz_clear, gz_valid, gz_data, gz_last, result, busy, done, timeout_err, frame_cnt, irq);
        end
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int c0, i0;
        c0 = n_clear;
        i0 = n_irq;
        start_frame(4, 0, 0);
        n_tests++;
        if (n_clear !== c0 + 1 || gz_clear !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_clear: got clears=%0d clr_now=%b busy=%b, required clears=%0d clr_now=0 busy=1",
                     n_clear - c0, gz_clear, busy, 1);
        end
        send(4, 'hA0, 4, 0);
        result_pulse(32'h1234);
        exp_result = 32'h1234;
        exp_frames++;
        n_tests++;
        if (result !== exp_result || done !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_frames || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL single_result: got res=%h done=%b busy=%b fc=%0d irq=%b, required res=%h done=1 busy=0 fc=%0d irq=1",
                     result, done, busy, frame_cnt, irq, exp_result, exp_frames);
        end
        tick();
        n_tests++;
        if (n_irq !== i0 + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_irq: got irqs=%0d pending=%0d, required irqs=1 pending=0", n_irq - i0, exp_q.size());
        end
    endtask

    task automatic test_decimation();
        start_frame(3, 2, 0);
        send(9, 0, 3, 2);
        result_pulse(32'h5555);
        exp_result = 32'h5555;
        exp_frames++;
        n_tests++;
        if (result !== exp_result || frame_cnt !== exp_frames || exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL decim_frame: got res=%h fc=%0d pending=%0d busy=%b, required res=%h fc=%0d pending=0 busy=0",
                     result, frame_cnt, exp_q.size(), busy, exp_result, exp_frames);
        end
    endtask

    task automatic test_continuous();
        int c0;
        c0 = n_clear;
        start_frame(2, 0, 1);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) cfg_continuous = 1'b0;
            send(2, 16 * f, 2, 0);
            result_pulse(32'hC000 + 32'(f));
            exp_result = 32'hC000 + 32'(f);
            exp_frames++;
            n_tests++;
            if (done !== 1'b1 || frame_cnt !== exp_frames || result !== exp_result || busy !== (f < 2)) begin
                n_fail++;
                $display("FAIL cont_frame%0d: got done=%b fc=%0d res=%h busy=%b, required done=1 fc=%0d res=%h busy=%b",
                         f, done, frame_cnt, result, busy, exp_frames, exp_result, f < 2);
            end
            if (f < 2) tick();
        end
        tick();
        n_tests++;
        if (n_clear !== c0 + 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_clears: got clears=%0d busy=%b, required clears=3 busy=0", n_clear - c0, busy);
        end
    endtask

    task automatic test_zero_n();
        int c0;
        c0 = n_clear;
        cfg_num_samples = '0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || n_clear !== c0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_n: got busy=%b clears=%0d done=%b, required busy=0 clears=0 done=1",
                     busy, n_clear - c0, done);
        end
    endtask

    task automatic test_timeout();
        int i0, k;
        i0 = n_irq;
        start_frame(1, 0, 0);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_done: got done=%b, required 0", done);
        end
        send(1, 7, 1, 0);
        k = 0;
        while (timeout_err !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        n_tests++;
        if (k != 256 || irq !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== exp_result) begin
            n_fail++;
            $display("FAIL timeout: got cycles=%0d irq=%b busy=%b done=%b res=%h, required cycles=256 irq=1 busy=0 done=0 res=%h",
                     k, irq, busy, done, result, exp_result);
        end
        tick();
        n_tests++;
        if (n_irq !== i0 + 1) begin
            n_fail++;
            $display("FAIL timeout_irq: got irqs=%0d, required 1", n_irq - i0);
        end
    endtask

    task automatic test_abort();
        int i0, c1;
        i0 = n_irq;
        start_frame(8, 0, 0);
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_timeout: got timeout_err=%b, required 0", timeout_err);
        end
        send(2, 'h50, 8, 0);
        cfg_abort = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 16'h0099;
        tick();
        cfg_abort = 1'b0;
        adc_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || gz_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b gz_valid=%b, required busy=0 gz_valid=0", busy, gz_valid);
        end
        repeat (3) begin
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
        result_pulse(32'hDEAD);
        tick();
        n_tests++;
        if (result !== exp_result || done !== 1'b0 || frame_cnt !== exp_frames || n_irq !== i0) begin
            n_fail++;
            $display("FAIL abort_late_result: got res=%h done=%b fc=%0d irqs=%0d, required res=%h done=0 fc=%0d irqs=0",
                     result, done, frame_cnt, n_irq - i0, exp_result, exp_frames);
        end
        c1 = n_clear;
        cfg_num_samples = 16'd4;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || n_clear !== c1) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b clears=%0d, required busy=0 clears=0", busy, n_clear - c1);
        end
        start_frame(1, 0, 0);
        send(1, 1, 1, 0);
        cfg_abort = 1'b1;
        result_pulse(32'hBEEF);
        cfg_abort = 1'b0;
        tick();
        n_tests++;
        if (result !== exp_result || done !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames || n_irq !== i0) begin
            n_fail++;
            $display("FAIL abort_vs_result: got res=%h done=%b busy=%b fc=%0d irqs=%0d, required res=%h done=0 busy=0 fc=%0d irqs=0",
                     result, done, busy, frame_cnt, n_irq - i0, exp_result, exp_frames);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        start_frame(8, 0, 0);
        send(3, 'h300, 8, 0);
        c0 = n_clear;
        ARESET = 1'b1;
        tick();
        n_tests++;
        if ({gz_clear, gz_valid, gz_data, gz_last, result, busy, done, timeout_err, frame_cnt, irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got clr=%b v=%b d=%h l=%b res=%h busy=%b done=%b to=%b fc=%0d irq=%b, required all 0",
                     gz_clear, gz_valid, gz_data, gz_last, result, busy, done, timeout_err, frame_cnt, irq);
        end
        ARESET = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (n_clear !== c0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got clears=%0d busy=%b pending=%0d, required clears=0 busy=0 pending=0",
                     n_clear - c0, busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_decimation();
        test_continuous();
        test_zero_n();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
